// File: rtl/cutthrough_pkg.sv
// Shared types for the cut-through filter stages: quote header layout,
// beat-0/beat-1 field offsets and the header parser state encoding.
package cutthrough_pkg;

  // Beat 0 carries msg_type and the 32-bit symbol field; only its low 24 bits are kept.
  localparam int MSG_TYPE_MSB  = 63;
  localparam int MSG_TYPE_LSB  = 56;
  localparam int SYMBOL_ID_MSB = 47;
  localparam int SYMBOL_ID_LSB = 24;
  // Beat 1 carries the Q16.16 price in its upper word.
  localparam int PRICE_MSB     = 63;
  localparam int PRICE_LSB     = 32;

  typedef struct packed {
    logic [7:0]  msg_type;
    logic [23:0] symbol_id;
    logic [31:0] price_q16_16;
  } header_t;

  typedef logic [1:0] parse_state_t;
  localparam parse_state_t ST_IDLE  = 2'd0;
  localparam parse_state_t ST_BEAT1 = 2'd1;
  localparam parse_state_t ST_BODY  = 2'd2;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer (main + skid register); payload passes unmodified, 1-cycle latency.
// Backpressure: s_rdy is a flop, low only while the skid register holds a beat.
module axis_skid_buffer #(
  parameter int WIDTH = 73
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_dat,
  input  logic             s_vld,
  output logic             s_rdy,
  output logic [WIDTH-1:0] m_dat,
  output logic             m_vld,
  input  logic             m_rdy
);

  logic [WIDTH-1:0] main_dat_q, main_dat_d;
  logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic             main_vld_q, main_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic             rdy_q, rdy_d;
  logic             s_acc;

  always_comb begin
    s_acc      = s_vld && rdy_q;
    main_dat_d = main_dat_q;
    main_vld_d = main_vld_q;
    skid_dat_d = skid_dat_q;
    skid_vld_d = skid_vld_q;
    if (!main_vld_q || m_rdy) begin
      // Main register frees up: drain the skid first so ordering is kept.
      if (skid_vld_q) begin
        main_dat_d = skid_dat_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = s_acc;
        if (s_acc) begin
          main_dat_d = s_dat;
        end
      end
    end else if (s_acc) begin
      skid_dat_d = s_dat;
      skid_vld_d = 1'b1;
    end
    rdy_d = !skid_vld_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_dat_q <= '0;
      main_vld_q <= 1'b0;
      skid_dat_q <= '0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      main_dat_q <= main_dat_d;
      main_vld_q <= main_vld_d;
      skid_dat_q <= skid_dat_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  assign s_rdy = rdy_q;
  assign m_dat = main_dat_q;
  assign m_vld = main_vld_q;

endmodule

// File: rtl/tick_header_parser.sv
// Forwards the 64-bit stream through a skid buffer (1 cycle) and extracts the quote header from beats 0/1.
// Backpressure only from master_tready; a stalled pulse consumer drops new headers (pulse_overflow), never data.
// Optional counters stat_pkts/stat_runts/stat_overflows via `TICK_PARSER_STATS_EN.
module tick_header_parser
  import cutthrough_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   slave_tdata,
  input  logic [WIDTH/8-1:0] slave_byteEnable,
  input  logic               slave_tvalid,
  input  logic               slave_tlast,
  output logic               slave_tready,
  output logic [WIDTH-1:0]   master_tdata,
  output logic [WIDTH/8-1:0] master_byteEnable,
  output logic               master_tvalid,
  output logic               master_tlast,
  input  logic               master_tready,
  output logic               pulse_valid,
  input  logic               pulse_ready,
  output header_t            pulse_header,
  output logic               pulse_overflow
`ifdef TICK_PARSER_STATS_EN
  ,
  output logic [31:0]        stat_pkts,
  output logic [15:0]        stat_runts,
  output logic [15:0]        stat_overflows
`endif
);

  localparam int BE_W  = WIDTH / 8;
  localparam int PAY_W = WIDTH + BE_W + 1;

  if (WIDTH != 64) begin : g_width_check
    $error("tick_header_parser: WIDTH must be 64");
  end

  logic [PAY_W-1:0] fwd_dat;

  axis_skid_buffer #(.WIDTH(PAY_W)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .s_dat ({slave_tdata, slave_byteEnable, slave_tlast}),
    .s_vld (slave_tvalid),
    .s_rdy (slave_tready),
    .m_dat (fwd_dat),
    .m_vld (master_tvalid),
    .m_rdy (master_tready)
  );

  assign {master_tdata, master_byteEnable, master_tlast} = fwd_dat;

  parse_state_t state_q, state_d;
  logic [7:0]   msg_type_q, msg_type_d;
  logic [23:0]  symbol_id_q, symbol_id_d;
  header_t      pulse_header_q, pulse_header_d;
  logic         pulse_valid_q, pulse_valid_d;
  logic         pulse_overflow_q, pulse_overflow_d;
  logic         beat_acc;
  logic         hdr_done;
  header_t      hdr_new;

  assign beat_acc = slave_tvalid && slave_tready;

  always_comb begin
    state_d              = state_q;
    msg_type_d           = msg_type_q;
    symbol_id_d          = symbol_id_q;
    hdr_done             = 1'b0;
    hdr_new.msg_type     = msg_type_q;
    hdr_new.symbol_id    = symbol_id_q;
    hdr_new.price_q16_16 = slave_tdata[PRICE_MSB:PRICE_LSB];
    if (beat_acc) begin
      case (state_q)
        ST_IDLE: begin
          msg_type_d  = slave_tdata[MSG_TYPE_MSB:MSG_TYPE_LSB];
          symbol_id_d = slave_tdata[SYMBOL_ID_MSB:SYMBOL_ID_LSB];
          if (!slave_tlast) begin
            state_d = ST_BEAT1;
          end
        end
        ST_BEAT1: begin
          hdr_done = 1'b1;
          state_d  = slave_tlast ? ST_IDLE : ST_BODY;
        end
        ST_BODY: begin
          if (slave_tlast) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A completing header may reuse the slot in the same cycle the consumer drains it.
    pulse_header_d   = pulse_header_q;
    pulse_valid_d    = pulse_valid_q;
    pulse_overflow_d = 1'b0;
    if (hdr_done) begin
      if (!pulse_valid_q || pulse_ready) begin
        pulse_header_d = hdr_new;
        pulse_valid_d  = 1'b1;
      end else begin
        pulse_overflow_d = 1'b1;
      end
    end else if (pulse_ready) begin
      pulse_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      msg_type_q       <= '0;
      symbol_id_q      <= '0;
      pulse_header_q   <= '0;
      pulse_valid_q    <= 1'b0;
      pulse_overflow_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      msg_type_q       <= msg_type_d;
      symbol_id_q      <= symbol_id_d;
      pulse_header_q   <= pulse_header_d;
      pulse_valid_q    <= pulse_valid_d;
      pulse_overflow_q <= pulse_overflow_d;
    end
  end

  assign pulse_valid    = pulse_valid_q;
  assign pulse_header   = pulse_header_q;
  assign pulse_overflow = pulse_overflow_q;

`ifdef TICK_PARSER_STATS_EN
  logic [31:0] stat_pkts_q, stat_pkts_d;
  logic [15:0] stat_runts_q, stat_runts_d;
  logic [15:0] stat_overflows_q, stat_overflows_d;

  always_comb begin
    stat_pkts_d      = stat_pkts_q;
    stat_runts_d     = stat_runts_q;
    stat_overflows_d = stat_overflows_q;
    if (beat_acc && slave_tlast && (stat_pkts_q != '1)) begin
      stat_pkts_d = stat_pkts_q + 32'd1;
    end
    if (beat_acc && slave_tlast && (state_q == ST_IDLE) && (stat_runts_q != '1)) begin
      stat_runts_d = stat_runts_q + 16'd1;
    end
    if (pulse_overflow_d && (stat_overflows_q != '1)) begin
      stat_overflows_d = stat_overflows_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts_q      <= '0;
      stat_runts_q     <= '0;
      stat_overflows_q <= '0;
    end else begin
      stat_pkts_q      <= stat_pkts_d;
      stat_runts_q     <= stat_runts_d;
      stat_overflows_q <= stat_overflows_d;
    end
  end

  assign stat_pkts      = stat_pkts_q;
  assign stat_runts     = stat_runts_q;
  assign stat_overflows = stat_overflows_q;
`endif

endmodule

// File: tb/tb_tick_header_parser.sv
// Bench for tick_header_parser: directed vector table, hand-written corner sequences and
// randomized traffic scored against a queue/slot reference model sampled on the falling edge.
module tb_tick_header_parser;
  import cutthrough_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] slave_tdata;
  logic [7:0]  slave_byteEnable;
  logic        slave_tvalid;
  logic        slave_tlast;
  logic        slave_tready;
  logic [63:0] master_tdata;
  logic [7:0]  master_byteEnable;
  logic        master_tvalid;
  logic        master_tlast;
  logic        master_tready;
  logic        pulse_valid;
  logic        pulse_ready;
  header_t     pulse_header;
  logic        pulse_overflow;
`ifdef TICK_PARSER_STATS_EN
  logic [31:0] stat_pkts;
  logic [15:0] stat_runts;
  logic [15:0] stat_overflows;
`endif

  tick_header_parser #(.WIDTH(64)) dut (
    .clk               (clk),
    .rst               (rst),
    .slave_tdata       (slave_tdata),
    .slave_byteEnable  (slave_byteEnable),
    .slave_tvalid      (slave_tvalid),
    .slave_tlast       (slave_tlast),
    .slave_tready      (slave_tready),
    .master_tdata      (master_tdata),
    .master_byteEnable (master_byteEnable),
    .master_tvalid     (master_tvalid),
    .master_tlast      (master_tlast),
    .master_tready     (master_tready),
    .pulse_valid       (pulse_valid),
    .pulse_ready       (pulse_ready),
    .pulse_header      (pulse_header),
    .pulse_overflow    (pulse_overflow)
`ifdef TICK_PARSER_STATS_EN
    ,
    .stat_pkts         (stat_pkts),
    .stat_runts        (stat_runts),
    .stat_overflows    (stat_overflows)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: in-flight beats, the pulse slot, and packet statistics.
  logic [72:0] exp_q[$];
  logic [63:0] got_hdr_q[$];
  logic        slot_full;
  logic [63:0] slot_hdr;
  logic        ovf_exp;
  int          beat_idx;
  logic [63:0] b0;
  logic        rst_prev = 1'b0;
  logic        armed    = 1'b0;
  int          ovf_cnt  = 0;
  int          m_pkts, m_runts, m_ovfs;

  always @(negedge clk) begin
    logic        acc;
    logic        pop;
    logic        done;
    logic [63:0] nh;
    if (rst_prev) begin
      check_bit("rst_slave_tready", slave_tready, 1'b0);
      check_bit("rst_master_tvalid", master_tvalid, 1'b0);
      check("rst_master_tdata", master_tdata, 64'h0);
      check("rst_master_be_last", 64'({master_byteEnable, master_tlast}), 64'h0);
      check_bit("rst_pulse_valid", pulse_valid, 1'b0);
      check("rst_pulse_header", pulse_header, 64'h0);
      check_bit("rst_pulse_overflow", pulse_overflow, 1'b0);
    end else if (armed) begin
      check_bit("slave_tready_occupancy", slave_tready, exp_q.size() < 2);
      check_bit("master_tvalid_occupancy", master_tvalid, exp_q.size() > 0);
      if (master_tvalid && exp_q.size() > 0) begin
        check("master_tdata", master_tdata, exp_q[0][72:9]);
        check("master_be_last", 64'({master_byteEnable, master_tlast}), 64'(exp_q[0][8:0]));
      end
      check_bit("pulse_valid", pulse_valid, slot_full);
      if (slot_full) check("pulse_header", pulse_header, slot_hdr);
      check_bit("pulse_overflow", pulse_overflow, ovf_exp);
    end
    if (pulse_overflow === 1'b1) ovf_cnt++;

    if (rst) begin
      exp_q.delete();
      slot_full = 1'b0;
      slot_hdr  = '0;
      ovf_exp   = 1'b0;
      beat_idx  = 0;
      b0        = '0;
      m_pkts    = 0;
      m_runts   = 0;
      m_ovfs    = 0;
      armed     = 1'b1;
    end else if (armed) begin
      acc  = slave_tvalid && slave_tready;
      pop  = master_tvalid && master_tready;
      done = 1'b0;
      nh   = '0;
      if (pulse_valid && pulse_ready) got_hdr_q.push_back(pulse_header);
      if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back({slave_tdata, slave_byteEnable, slave_tlast});
        if (beat_idx == 0) begin
          b0 = slave_tdata;
        end else if (beat_idx == 1) begin
          done = 1'b1;
          nh   = {b0[63:56], b0[47:24], slave_tdata[63:32]};
        end
        if (slave_tlast) begin
          m_pkts++;
          if (beat_idx == 0) m_runts++;
          beat_idx = 0;
        end else begin
          beat_idx++;
        end
      end
      ovf_exp = 1'b0;
      if (done) begin
        if (!slot_full || pulse_ready) begin
          slot_full = 1'b1;
          slot_hdr  = nh;
        end else begin
          ovf_exp = 1'b1;
          m_ovfs++;
        end
      end else if (pulse_ready) begin
        slot_full = 1'b0;
      end
    end
    rst_prev = rst;
  end

  // Ready drivers: fixed or 50% random, updated 2 time units after each rising edge.
  logic mrdy_rand = 1'b0;
  logic prdy_rand = 1'b0;
  logic prdy_fix  = 1'b1;

  initial begin
    master_tready = 1'b1;
    pulse_ready   = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      master_tready = mrdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      pulse_ready   = prdy_rand ? ($urandom_range(0, 1) == 1) : prdy_fix;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] be, input logic last);
    int   waited = 0;
    logic acc    = 1'b0;
    slave_tdata      = d;
    slave_byteEnable = be;
    slave_tlast      = last;
    slave_tvalid     = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = slave_tready;
      @(posedge clk);
      #1;
      if (!acc) begin
        waited++;
        if (waited > 200) begin
          n_checks++;
          n_fail++;
          $display("FAIL beat_accept_timeout: slave_tready stayed 0 for %0d cycles, required 1", waited);
          break;
        end
      end
    end
    slave_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [63:0] d0, input logic [63:0] d1, input int len);
    logic [63:0] d;
    for (int k = 0; k < len; k++) begin
      d = (k == 0) ? d0 : (k == 1) ? d1 : {$urandom, $urandom};
      send_beat(d, 8'($urandom), k == len - 1);
    end
  endtask

  typedef struct {
    logic [63:0] beat0;
    logic [63:0] beat1;
    int          len;
    int          exp_pulses;
    logic [63:0] exp_hdr;
  } vec_t;

  vec_t vecs [0:4];

  initial begin
    int n0;
    int n1;
    int len;
    rst              = 1'b1;
    slave_tvalid     = 1'b0;
    slave_tdata      = '0;
    slave_byteEnable = '0;
    slave_tlast      = 1'b0;
    vecs[0] = '{64'h5100_4141_5000_0000, 64'h0064_8000_DEAD_BEEF, 3, 1, 64'h51_414150_00648000};
    vecs[1] = '{64'h5100_4141_5000_0000, 64'h0,                   1, 0, 64'h0};
    vecs[2] = '{64'hA5FF_1234_56AB_CDEF, 64'hCAFE_BABE_0000_0000, 2, 1, 64'hA5_123456_CAFEBABE};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_FFFF_FFFF, 5, 1, 64'hFF_FFFFFF_00000001};
    vecs[4] = '{64'h00AA_0000_0000_0000, 64'h8000_0000_1234_5678, 2, 1, 64'h00_000000_80000000};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Directed vectors, all readies held high.
    prdy_fix = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n0 = got_hdr_q.size();
      send_pkt(vecs[i].beat0, vecs[i].beat1, vecs[i].len);
      idle(4);
      check_int("tbl_pulse_count", got_hdr_q.size() - n0, vecs[i].exp_pulses);
      if (vecs[i].exp_pulses > 0 && got_hdr_q.size() > n0)
        check("tbl_header", got_hdr_q[$], vecs[i].exp_hdr);
    end

    // Stalled consumer across two back-to-back headers: first one held, one overflow.
    prdy_fix = 1'b0;
    idle(1);
    n0 = ovf_cnt;
    send_pkt(64'hC3_00_ABCDEF_000000, 64'h1111_2222_3333_4444, 2);
    send_pkt(64'h7E_00_010203_000000, 64'h5555_6666_7777_8888, 2);
    idle(3);
    check_int("ovf_strobe_count", ovf_cnt - n0, 1);
    check_bit("ovf_pulse_valid_held", pulse_valid, 1'b1);
    check("ovf_header_held", pulse_header, 64'hC3_ABCDEF_11112222);
    n1 = got_hdr_q.size();
    prdy_fix = 1'b1;
    idle(2);
    check_int("ovf_release_count", got_hdr_q.size() - n1, 1);
    if (got_hdr_q.size() > n1) check("ovf_release_header", got_hdr_q[$], 64'hC3_ABCDEF_11112222);
    check_bit("ovf_slot_empty", pulse_valid, 1'b0);

    // Header completes in the same cycle the previous one is accepted.
    prdy_fix = 1'b0;
    send_pkt(64'h42_00_AAAAAA_000000, 64'h0001_0000_0000_0000, 2);
    idle(2);
    n0 = ovf_cnt;
    n1 = got_hdr_q.size();
    send_beat(64'h43_00_BBBBBB_000000, 8'hFF, 1'b0);
    prdy_fix = 1'b1;
    send_beat(64'h0002_0000_0000_0000, 8'hFF, 1'b1);
    prdy_fix = 1'b0;
    idle(1);
    check_bit("same_cycle_pulse_valid", pulse_valid, 1'b1);
    check("same_cycle_new_header", pulse_header, 64'h43_BBBBBB_00020000);
    check_int("same_cycle_no_overflow", ovf_cnt - n0, 0);
    check_int("same_cycle_handshake", got_hdr_q.size() - n1, 1);
    if (got_hdr_q.size() > n1) check("same_cycle_old_header", got_hdr_q[$], 64'h42_AAAAAA_00010000);
    prdy_fix = 1'b1;
    idle(2);

    // Reset after beat 0: the partial header must not leak into the next packet.
    n1 = got_hdr_q.size();
    send_beat(64'h99_00_DEAD00_000000, 8'hFF, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
    send_pkt(64'h61_00_123123_000000, 64'h7FFF_0001_0000_0000, 3);
    idle(4);
    check_int("rst_pulse_count", got_hdr_q.size() - n1, 1);
    if (got_hdr_q.size() > n1) check("rst_fresh_header", got_hdr_q[$], 64'h61_123123_7FFF0001);

    // Random traffic with random readies, including one 10-beat packet.
    mrdy_rand = 1'b1;
    prdy_rand = 1'b1;
    for (int p = 0; p < 40; p++) begin
      len = (p == 20) ? 10 : int'($urandom_range(1, 6));
      send_pkt({$urandom, $urandom}, {$urandom, $urandom}, len);
      idle(int'($urandom_range(0, 2)));
    end
    mrdy_rand = 1'b0;
    prdy_rand = 1'b0;
    prdy_fix  = 1'b1;
    idle(10);
    check_bit("drain_master_tvalid", master_tvalid, 1'b0);
    check_bit("drain_pulse_valid", pulse_valid, 1'b0);
    check_bit("drain_slave_tready", slave_tready, 1'b1);

`ifdef TICK_PARSER_STATS_EN
    check("stat_pkts", 64'(stat_pkts), 64'(m_pkts));
    check("stat_runts", 64'(stat_runts), 64'(m_runts));
    check("stat_overflows", 64'(stat_overflows), 64'(m_ovfs));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at t=%0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tick_header_parser.md
# tick_header_parser

Downstream stage of the cut-through filter. Consumes the filtered 64-bit AXI-stream, forwards it unchanged through a registered skid buffer, and extracts the quote header (msg_type, symbol_id, price) from the first two beats of each packet. The header goes to the strategy logic on a valid/ready pulse channel, with overflow detection when the consumer stalls.

## Interface
- WIDTH, 64: tdata width in bits; fixed at 64, elaborate-time error otherwise.
- clk  in  1: single clock; all logic on rising edge.
- rst  in  1: reset is synchronous and active-high.
- slave_tdata  in  WIDTH: input beat data.
- slave_byteEnable  in  WIDTH/8: byte enables, forwarded unchanged.
- slave_tvalid  in  1: input beat valid.
- slave_tlast  in  1: last beat of packet.
- slave_tready  out  1: input ready; driven by the skid buffer.
- master_tdata  out  WIDTH: forwarded data.
- master_byteEnable  out  WIDTH/8: forwarded byte enables.
- master_tvalid  out  1: output valid.
- master_tlast  out  1: forwarded tlast.
- master_tready  in  1: downstream ready.
- pulse_valid  out  1: header available.
- pulse_ready  in  1: consumer accepts the header.
- pulse_header  out  header_t: {msg_type[7:0], symbol_id[23:0], price_q16_16[31:0]}.
- pulse_overflow  out  1: one-cycle strobe when a completed header is discarded.

## Operation
- Data path: a two-entry skid buffer (main plus skid register). The payload is {tdata, byteEnable, tlast}, never modified.
- Parser FSM advances only on an accepted input beat (slave_tvalid && slave_tready).
  - IDLE: beat 0. Capture msg_type = tdata[63:56] and symbol_id = tdata[47:24], the low 24 bits of the 32-bit symbol field. If tlast is set, the packet is a runt: no pulse is generated and the FSM stays in IDLE. Otherwise the FSM goes to BEAT1.
  - BEAT1: capture price_q16_16 = tdata[63:32]. The header is complete on this beat. If tlast is set, go to IDLE; otherwise go to BODY.
  - BODY: ignore the data. Go to IDLE on tlast.
- Pulse channel:
  - On header completion, if the pulse slot is empty, or pulse_ready is high in the same cycle, load pulse_header and set pulse_valid to 1 on the next cycle.
  - If pulse_valid is high and pulse_ready is low, discard the new header. The held header is unchanged, and pulse_overflow pulses for one cycle.
  - pulse_valid is cleared on pulse_ready when no new header completes in that cycle.
- Parsing never back-pressures the data path. Header overflow never drops stream data.

## Timing
- Data latency: 1 cycle from input accept to master_tvalid.
- Throughput: one beat per cycle while master_tready is high.
- slave_tready is registered: it is high whenever the skid register is empty.
- Once master_tvalid is asserted, master_tdata, master_byteEnable and master_tlast hold stable until master_tready.
- pulse_valid rises in the cycle after the BEAT1 accept, so the first pulse comes 2 cycles after the beat-0 accept at minimum.
- Reset values:
  - master_tvalid = 0, slave_tready = 0 during rst and 1 in the first cycle after rst.
  - pulse_valid = 0, pulse_overflow = 0, pulse_header = 0.
  - FSM = IDLE. master_tdata, master_byteEnable and master_tlast = 0.
- Reset mid-packet: the partial header and all buffered beats are discarded. The next accepted beat is treated as beat 0.
- Simultaneous header completion and pulse_ready: the handshake completes, the new header loads, and pulse_valid stays 1. No overflow is raised.

## Configuration
- Macro `TICK_PARSER_STATS_EN`.
- Defined: adds three outputs:
  - stat_pkts, 32 bits: incremented on every accepted tlast.
  - stat_runts, 16 bits: incremented on single-beat packets.
  - stat_overflows, 16 bits: incremented with pulse_overflow.
  - All three counters saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package cutthrough_pkg holds:
  - header_t.
  - Field-offset localparams: MSG_TYPE_MSB/LSB, SYMBOL_ID_MSB/LSB, PRICE_MSB/LSB.
  - The parser state enum.
- Sub-module axis_skid_buffer (parameter WIDTH) carries the data path. It is reusable by other stages.

## Test plan
- 3-beat packet, beat0 = 0x51_00_41_41_50_00_00_00, beat1 = 0x0064_8000_xxxx_xxxx, pulse_ready held 1 -> one pulse with msg_type 0x51, symbol_id 0x414150, price 0x00648000. Data out matches data in with 1-cycle latency.
- Single-beat packet (tlast on beat 0) -> forwarded intact, no pulse_valid, stat_runts = 1 when stats are enabled.
- pulse_ready held 0 across two back-to-back 2-beat packets -> first header held, pulse_overflow strobes once, stat_overflows = 1. Asserting pulse_ready then delivers the first header.
- master_tready toggled randomly at 50% during a 10-beat packet -> no beat lost or duplicated, slave_tready low only when the skid register is full.
- rst asserted for one cycle after beat0 of a packet -> next packet parsed correctly from its beat0, no stale pulse.
- Header completes in the same cycle pulse_ready accepts the previous header -> new header loaded, pulse_valid stays 1, no overflow.
